// File: rtl/alu_datamem_seq.sv
// Multicycle ALU / register file / data memory datapath with a valid/ready instruction port.
// Each accepted instruction runs IDLE -> EXEC -> [MEM] -> WB and retires with a one-cycle done pulse.
module alu_datamem_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_kind,
  input  logic [3:0]               in_aluop,
  input  logic [$clog2(NREGS)-1:0] in_rd,
  input  logic [$clog2(NREGS)-1:0] in_rs,
  input  logic [$clog2(NREGS)-1:0] in_rt,
  input  logic [WIDTH-1:0]         in_imm,
  input  logic                     ovf_clr,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic                     take_branch,
  output logic                     ovf_sticky,
  output logic                     busy
);
  localparam int unsigned RAW = $clog2(NREGS);
  localparam int unsigned MAW = $clog2(DEPTH);
  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [1:0] K_ALU_RR = 2'd0;
  localparam logic [1:0] K_LOAD   = 2'd2;
  localparam logic [1:0] K_STORE  = 2'd3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_BEQ = 4'd8;
  localparam logic [3:0] OP_BNE = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;

  state_t           r_state;
  logic             r_ready;
  logic             r_done;
  logic             r_branch;
  logic             r_ovf_sticky;
  logic [WIDTH-1:0] r_result;

  logic [1:0]       r_kind;
  logic [3:0]       r_op;
  logic [RAW-1:0]   r_rd;
  logic [RAW-1:0]   r_rs;
  logic [RAW-1:0]   r_rt;
  logic [WIDTH-1:0] r_imm;

  logic [WIDTH-1:0] r_f;
  logic [WIDTH-1:0] r_sdata;
  logic [WIDTH-1:0] r_rdata;
  logic [MAW-1:0]   r_addr;
  logic             r_ovf;
  logic             r_br_exec;
  logic             r_wr_en;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_mem  [DEPTH];

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_rt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_f;
  logic             w_ovf_add;
  logic             w_ovf_sub;
  logic             w_ovf;
  logic             w_br;
  logic             w_is_mem;
  logic             w_is_branch;
  logic [MAW-1:0]   w_addr;
  logic             w_mem_we;

  // Operand fetch and ALU, evaluated from the latched instruction during EXEC.
  always_comb begin
    w_a         = r_regs[r_rs];
    w_rt        = r_regs[r_rt];
    w_b         = (r_kind == K_ALU_RR) ? w_rt : r_imm;
    w_sum       = w_a + w_b;
    w_diff      = w_a - w_b;
    w_ovf_add   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
    w_ovf_sub   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
    w_addr      = w_sum[MAW-1:0];
    w_is_mem    = r_kind[1];
    w_is_branch = 1'b0;
    w_f         = w_sum;
    w_ovf       = 1'b0;
    w_br        = 1'b0;
    case (r_op)
      OP_ADD: w_ovf = w_ovf_add;
      OP_SUB: begin
        w_f   = w_diff;
        w_ovf = w_ovf_sub;
      end
      OP_AND: w_f = w_a & w_b;
      OP_OR:  w_f = w_a | w_b;
      OP_XOR: w_f = w_a ^ w_b;
      OP_SLL: w_f = w_a << w_b[SHW-1:0];
      OP_SRL: w_f = w_a >> w_b[SHW-1:0];
      OP_SLT: begin
        w_f    = '0;
        w_f[0] = $signed(w_a) < $signed(w_b);
      end
      OP_BEQ: begin
        w_f         = w_diff;
        w_br        = (w_a == w_b);
        w_is_branch = 1'b1;
      end
      OP_BNE: begin
        w_f         = w_diff;
        w_br        = (w_a != w_b);
        w_is_branch = 1'b1;
      end
      default: w_ovf = w_ovf_add;
    endcase
    w_mem_we = (r_state == S_MEM) && (r_kind == K_STORE) && !reset;
  end

  // Data memory: never reset; a reset in the MEM cycle suppresses the store.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_addr] <= r_sdata;
    if (r_state == S_MEM) r_rdata <= r_mem[r_addr];
  end

  // Sequencer, register file and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b1;
      r_done       <= 1'b0;
      r_branch     <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_result     <= '0;
      r_kind       <= '0;
      r_op         <= '0;
      r_rd         <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_imm        <= '0;
      r_f          <= '0;
      r_sdata      <= '0;
      r_addr       <= '0;
      r_ovf        <= 1'b0;
      r_br_exec    <= 1'b0;
      r_wr_en      <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
    end else begin
      r_done <= 1'b0;
      if (ovf_clr) r_ovf_sticky <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_kind  <= in_kind;
            r_op    <= in_aluop;
            r_rd    <= in_rd;
            r_rs    <= in_rs;
            r_rt    <= in_rt;
            r_imm   <= in_imm;
            r_ready <= 1'b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_f       <= w_is_mem ? WIDTH'(w_addr) : w_f;
          r_addr    <= w_addr;
          r_sdata   <= w_rt;
          r_ovf     <= w_ovf && !w_is_mem;
          r_br_exec <= w_br && !w_is_mem;
          r_wr_en   <= (r_kind != K_STORE) && !(w_is_branch && !w_is_mem) && (r_rd != '0);
          r_state   <= w_is_mem ? S_MEM : S_WB;
        end
        S_MEM: r_state <= S_WB;
        S_WB: begin
          if (r_wr_en) r_regs[r_rd] <= (r_kind == K_LOAD) ? r_rdata : r_f;
          r_result <= (r_kind == K_LOAD) ? r_rdata : r_f;
          r_branch <= r_br_exec;
          if (r_ovf) r_ovf_sticky <= 1'b1;
          r_done   <= 1'b1;
          r_ready  <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = r_ready;
  assign busy        = ~r_ready;
  assign done        = r_done;
  assign result      = r_result;
  assign take_branch = r_branch;
  assign ovf_sticky  = r_ovf_sticky;

endmodule

// File: tb/tb_alu_datamem_seq.sv
// Randomized self-checking bench for alu_datamem_seq against a signed-integer
// reference model of the register file, data memory and sticky overflow flag.
module tb_alu_datamem_seq;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned NREGS = 8;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned RAW   = $clog2(NREGS);
  localparam int unsigned SHW   = $clog2(WIDTH);
  localparam longint      MOD   = longint'(1) << WIDTH;
  localparam longint      SMAX  = (longint'(1) << (WIDTH - 1)) - 1;
  localparam longint      SMIN  = -(longint'(1) << (WIDTH - 1));

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_kind;
  logic [3:0]       in_aluop;
  logic [RAW-1:0]   in_rd;
  logic [RAW-1:0]   in_rs;
  logic [RAW-1:0]   in_rt;
  logic [WIDTH-1:0] in_imm;
  logic             ovf_clr;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             take_branch;
  logic             ovf_sticky;
  logic             busy;

  alu_datamem_seq #(.WIDTH(WIDTH), .NREGS(NREGS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_aluop(in_aluop), .in_rd(in_rd), .in_rs(in_rs),
    .in_rt(in_rt), .in_imm(in_imm), .ovf_clr(ovf_clr), .done(done),
    .result(result), .take_branch(take_branch), .ovf_sticky(ovf_sticky),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint m_reg [NREGS];
  longint m_mem [DEPTH];
  bit     m_ovf;
  int     n_total;
  int     n_bad;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint to_signed(input longint v);
    return (v > SMAX) ? v - MOD : v;
  endfunction

  function automatic longint wrap(input longint v);
    return ((v % MOD) + MOD) % MOD;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NREGS); i++) m_reg[i] = 0;
    m_ovf = 1'b0;
  endtask

  // Issue one instruction, predict its effect, and check latency and retired outputs.
  task automatic issue(input int kind, input int op, input int rd, input int rs, input int rt,
                       input longint imm, input bit clr_wb);
    longint a, b, f, full;
    bit     br, ov, wr;
    int     lat, n, addr, waits;
    bit     seen;
    a = m_reg[rs];
    b = (kind == 0) ? m_reg[rt] : wrap(imm);
    f = 0; br = 0; ov = 0; wr = 0; lat = 2;
    if (kind < 2) begin
      wr = 1;
      case (op)
        1: begin full = to_signed(a) - to_signed(b); f = wrap(a - b); ov = (full > SMAX) || (full < SMIN); end
        2: f = a & b;
        3: f = a | b;
        4: f = a ^ b;
        5: f = wrap(a << (b % (1 << SHW)));
        6: f = a >> (b % (1 << SHW));
        7: f = (to_signed(a) < to_signed(b)) ? 1 : 0;
        8: begin f = wrap(a - b); br = (a == b); wr = 0; end
        9: begin f = wrap(a - b); br = (a != b); wr = 0; end
        default: begin full = to_signed(a) + to_signed(b); f = wrap(a + b); ov = (full > SMAX) || (full < SMIN); end
      endcase
    end else begin
      lat  = 3;
      addr = int'(wrap(a + b) % DEPTH);
      if (kind == 2) begin
        f  = m_mem[addr];
        wr = 1;
      end else begin
        f = addr;
        m_mem[addr] = m_reg[rt];
      end
    end
    if (wr && rd != 0) m_reg[rd] = f;
    m_ovf = clr_wb ? ov : (m_ovf | ov);

    @(negedge clk);
    in_kind  = 2'(kind);
    in_aluop = 4'(op);
    in_rd    = RAW'(rd);
    in_rs    = RAW'(rs);
    in_rt    = RAW'(rt);
    in_imm   = WIDTH'(imm);
    in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check_eq("ready_before_accept", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("ready_low_in_exec", 64'(in_ready), 64'(0));
    check_eq("busy_in_exec", 64'(busy), 64'(1));
    n = 0;
    seen = 1'b0;
    while (n < 8 && !seen) begin
      if (clr_wb && n == lat - 1) ovf_clr = 1'b1;
      @(posedge clk);
      #1;
      ovf_clr = 1'b0;
      n++;
      if (done) seen = 1'b1;
    end
    check_eq("latency", 64'(n), 64'(lat));
    check_eq("result", 64'(result), 64'(f));
    check_eq("take_branch", 64'(take_branch), 64'(br));
    check_eq("ovf_sticky", 64'(ovf_sticky), 64'(m_ovf));
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    m_ovf = 1'b0;
    check_eq("ovf_after_clr", 64'(ovf_sticky), 64'(0));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     kind, op;
    longint imm;
    n_total = 0; n_bad = 0;
    reset = 1'b1; in_valid = 1'b0; in_kind = '0; in_aluop = '0;
    in_rd = '0; in_rs = '0; in_rt = '0; in_imm = '0; ovf_clr = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_result", 64'(result), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_branch", 64'(take_branch), 64'(0));
    check_eq("rst_ovf", 64'(ovf_sticky), 64'(0));
    check_eq("rst_ready", 64'(in_ready), 64'(1));
    check_eq("rst_busy", 64'(busy), 64'(0));

    // Give every memory word a known value.
    for (int i = 0; i < int'(DEPTH); i++) issue(3, 0, 0, 0, 0, longint'(i), 1'b0);

    // Basic ALU-imm ADD and single-cycle done.
    issue(1, 0, 1, 0, 0, 5, 1'b0);
    @(posedge clk);
    #1;
    check_eq("done_one_cycle", 64'(done), 64'(0));
    issue(1, 0, 2, 1, 0, 0, 1'b0);

    // Signed overflow, clear, and set-beats-clear.
    issue(1, 0, 1, 0, 0, SMAX, 1'b0);
    issue(1, 0, 2, 0, 0, 1, 1'b0);
    issue(0, 0, 3, 1, 2, 0, 1'b0);
    pulse_clr();
    issue(0, 0, 3, 1, 2, 0, 1'b1);
    issue(0, 1, 3, 3, 2, 0, 1'b0);

    // Store with wrapped address, load back.
    issue(1, 0, 1, 0, 0, 'h1234, 1'b0);
    issue(3, 0, 0, 0, 1, longint'(DEPTH) + 3, 1'b0);
    issue(2, 0, 4, 0, 0, 3, 1'b0);
    issue(1, 0, 5, 4, 0, 0, 1'b0);

    // Branches, then a non-branch clears take_branch.
    issue(1, 0, 1, 0, 0, 9, 1'b0);
    issue(1, 0, 2, 0, 0, 9, 1'b0);
    issue(0, 8, 5, 1, 2, 0, 1'b0);
    issue(0, 9, 5, 1, 2, 0, 1'b0);
    issue(0, 8, 6, 1, 4, 0, 1'b0);
    issue(1, 0, 6, 0, 0, 1, 1'b0);
    issue(1, 0, 7, 5, 0, 0, 1'b0);

    // R0 is hard zero, SLT signed, shift amount truncation.
    issue(1, 0, 0, 0, 0, 7, 1'b0);
    issue(1, 0, 7, 0, 0, 0, 1'b0);
    issue(1, 0, 1, 0, 0, MOD - 1, 1'b0);
    issue(1, 7, 3, 1, 0, 1, 1'b0);
    issue(1, 5, 3, 2, 0, longint'(WIDTH) + 1, 1'b0);
    issue(1, 6, 3, 1, 0, longint'(WIDTH) + 2, 1'b0);

    // Reset during the MEM cycle of a store aborts it.
    issue(1, 0, 1, 0, 0, 'hABC, 1'b0);
    @(negedge clk);
    in_kind = 2'd3; in_aluop = '0; in_rd = '0; in_rs = '0; in_rt = RAW'(1);
    in_imm = WIDTH'(5); in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_eq("abort_result", 64'(result), 64'(0));
    check_eq("abort_done", 64'(done), 64'(0));
    check_eq("abort_branch", 64'(take_branch), 64'(0));
    check_eq("abort_ovf", 64'(ovf_sticky), 64'(0));
    check_eq("abort_ready", 64'(in_ready), 64'(1));
    check_eq("abort_busy", 64'(busy), 64'(0));
    issue(2, 0, 1, 0, 0, 5, 1'b0);
    issue(0, 0, 2, 1, 1, 0, 1'b0);

    // Random instruction stream.
    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 3));
      op   = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) imm = longint'($urandom_range(0, 20));
      else imm = longint'($urandom) % MOD;
      issue(kind, op, int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, NREGS - 1)),
            int'($urandom_range(0, NREGS - 1)), imm, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 19) == 0) pulse_clr();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_datamem_seq.md
Name: alu_datamem_seq

Overview:
Parametrised, self-sequencing successor to the manually-probed ALU/regfile/data-memory datapath. It accepts one decoded instruction per valid/ready handshake and executes it with a multicycle FSM. The block owns its register file, ALU and data memory, and reports the result, a branch decision and a sticky overflow flag. It sits between an instruction source (VIO, later a fetch unit) and the 7-segment display adaptor, which is driven from result.

Parameters:
WIDTH, 16, datapath and register width in bits (>=8).
NREGS, 8, register count, power of 2; register 0 reads as zero and ignores writes.
DEPTH, 256, data memory words, power of 2.
RAW = $clog2(NREGS); MAW = $clog2(DEPTH) (localparams).

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  instruction fields valid.
in_ready  out  1  block can accept an instruction (high only in IDLE).
in_kind  in  2  0=ALU reg-reg, 1=ALU reg-imm, 2=LOAD, 3=STORE.
in_aluop  in  4  ALU operation (ALU kinds only).
in_rd  in  RAW  destination register.
in_rs  in  RAW  source register A.
in_rt  in  RAW  source register B / store data.
in_imm  in  WIDTH  immediate operand.
ovf_clr  in  1  clears ovf_sticky.
done  out  1  one-cycle pulse when the instruction retires.
result  out  WIDTH  ALU result, or load data for LOAD; held until the next retire.
take_branch  out  1  branch decision of the last retired instruction.
ovf_sticky  out  1  set by any signed ADD/SUB overflow.
busy  out  1  equals ~in_ready.

Behaviour:
- Reset (synchronous, active-high, highest priority): state=IDLE, all registers=0, result=0, take_branch=0, ovf_sticky=0, done=0. Memory contents are not cleared. Reset mid-instruction aborts it with no register or memory write.
- Handshake: in_valid && in_ready in IDLE latches all in_* fields and moves to EXEC. Inputs are ignored outside IDLE.
- Operands: A=R[rs], B=R[rt] (kind 0) or in_imm (kinds 1-3). Registers are read in EXEC.
- ALU ops, all modulo 2^WIDTH:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL and 6 SRL, shift amount B[$clog2(WIDTH)-1:0].
  - 7 SLT signed (result 1/0).
  - 8 BEQ: take_branch=(A==B), result=A-B, no register write.
  - 9 BNE: take_branch=(A!=B), same.
  - 10-15 behave as ADD.
- LOAD/STORE: address = (R[rs]+in_imm)[MAW-1:0], wrapping, no fault. STORE writes R[rt] to that address.
- FSM: IDLE -> EXEC -> (MEM if LOAD or STORE) -> WB -> IDLE.
  - EXEC: computes the ALU/address result into a register.
  - MEM: STORE performs the write in this cycle. LOAD performs a synchronous read, with data valid entering WB.
  - WB: writes R[rd] for kinds 0-2 (except ops 8/9, and except rd=0). Updates result, updates take_branch (0 for non-branch ops) and pulses done.
- Latency from the accept edge to done: ALU = 2 cycles; LOAD/STORE = 3 cycles. Maximum throughput is one instruction per 3 cycles (ALU) or 4 cycles (memory).
- STORE: result = the address zero-extended; no register write.
- Overflow: ADD (op 0, or ops 10-15) sets ovf on sign(A)==sign(B) && sign(F)!=sign(A). SUB sets it on sign(A)!=sign(B) && sign(F)!=sign(A). ovf_sticky is set in WB.
  - ovf_clr clears ovf_sticky in any state.
  - If a set and ovf_clr land in the same cycle, the set wins.
- A later instruction reads the value written by an earlier one, because WB completes before the next accept.
- Register 0 always reads 0.

Test Plan:
1. Reset, then ALU-imm ADD rd=1, rs=0, imm=5 -> done exactly 2 cycles after accept; result=5; R1=5; in_ready low during EXEC/WB.
2. R1=0x7FFF, R2=1, ADD rd=3 -> result=0x8000, ovf_sticky=1. Pulse ovf_clr -> 0. Repeat with ovf_clr held in the WB cycle -> ovf_sticky stays 1.
3. STORE rt=1 (R1=0x1234), rs=0, imm=DEPTH+3, then LOAD rd=4 imm=3 -> R4=0x1234 (address wrap); each instruction takes 3 cycles to done.
4. R1=R2=9: BEQ -> take_branch=1, result=0, no write; BNE -> take_branch=0. A following ADD -> take_branch=0.
5. ADD rd=0 imm=7 -> R0 still reads 0. SLT on A=0xFFFF, B=1 -> result=1. SLL with B=17 (WIDTH=16) -> shift by 1.
6. Assert reset during the MEM cycle of a STORE -> the memory word is unchanged, the FSM is in IDLE, all outputs are 0. Rerun tests 1-3 with WIDTH=32, NREGS=16, DEPTH=1024.
